// File: rtl/arcade_input_pkg.sv
// Package: arcade_input_pkg
// Shared constants for the arcade input front end. It holds:
//  - the control-byte bit indices (CTRL_*);
//  - the hps_io joystick bit indices (JOY_*);
//  - the 9-bit {extended, scancode} key constants;
//  - the DIP download index;
//  - helpers that decode key events and reorder bytes.
// Internally, player inputs are carried in joystick bit order.
// They are converted to the core's control-byte order only at the output register.
package arcade_input_pkg;

   // Control byte presented to the core (active-low on the port)
   localparam int CTRL_COIN  = 7;
   localparam int CTRL_TRIG2 = 6;
   localparam int CTRL_START = 5;
   localparam int CTRL_UP    = 4;
   localparam int CTRL_DOWN  = 3;
   localparam int CTRL_TRIG1 = 2;
   localparam int CTRL_RIGHT = 1;
   localparam int CTRL_LEFT  = 0;

   // hps_io joystick word, low byte
   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_TRIG1 = 4;
   localparam int JOY_TRIG2 = 5;
   localparam int JOY_START = 6;
   localparam int JOY_COIN  = 7;

   // Per keyboard player: 8 keys in joystick order plus the function key (F1/F2)
   localparam int KEY_FN          = 8;
   localparam int KEYS_PER_PLAYER = 9;
   localparam int NUM_KEYS        = 2 * KEYS_PER_PLAYER;

   localparam logic [7:0] DSW_INDEX = 8'd254;

   // {extended, scancode}
   localparam logic [8:0] SC_P0_UP    = 9'h175;
   localparam logic [8:0] SC_P0_DOWN  = 9'h172;
   localparam logic [8:0] SC_P0_LEFT  = 9'h16B;
   localparam logic [8:0] SC_P0_RIGHT = 9'h174;
   localparam logic [8:0] SC_P0_TRIG1 = 9'h029;
   localparam logic [8:0] SC_P0_TRIG2 = 9'h014;
   localparam logic [8:0] SC_P0_START = 9'h016;
   localparam logic [8:0] SC_P0_COIN  = 9'h02E;
   localparam logic [8:0] SC_F1       = 9'h005;
   localparam logic [8:0] SC_P1_UP    = 9'h02D;
   localparam logic [8:0] SC_P1_DOWN  = 9'h02B;
   localparam logic [8:0] SC_P1_LEFT  = 9'h023;
   localparam logic [8:0] SC_P1_RIGHT = 9'h034;
   localparam logic [8:0] SC_P1_TRIG1 = 9'h01C;
   localparam logic [8:0] SC_P1_TRIG2 = 9'h01B;
   localparam logic [8:0] SC_P1_START = 9'h01E;
   localparam logic [8:0] SC_P1_COIN  = 9'h036;
   localparam logic [8:0] SC_F2       = 9'h006;

   // One-hot key-state mask for a code.
   // Player 1 keys sit at offset KEYS_PER_PLAYER.
   // Unknown codes return zero.
   function automatic logic [NUM_KEYS-1:0] key_decode(input logic [8:0] code);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      case (code)
         SC_P0_RIGHT: m[JOY_RIGHT] = 1'b1;
         SC_P0_LEFT:  m[JOY_LEFT]  = 1'b1;
         SC_P0_DOWN:  m[JOY_DOWN]  = 1'b1;
         SC_P0_UP:    m[JOY_UP]    = 1'b1;
         SC_P0_TRIG1: m[JOY_TRIG1] = 1'b1;
         SC_P0_TRIG2: m[JOY_TRIG2] = 1'b1;
         SC_P0_START: m[JOY_START] = 1'b1;
         SC_P0_COIN:  m[JOY_COIN]  = 1'b1;
         SC_F1:       m[KEY_FN]    = 1'b1;
         SC_P1_RIGHT: m[KEYS_PER_PLAYER + JOY_RIGHT] = 1'b1;
         SC_P1_LEFT:  m[KEYS_PER_PLAYER + JOY_LEFT]  = 1'b1;
         SC_P1_DOWN:  m[KEYS_PER_PLAYER + JOY_DOWN]  = 1'b1;
         SC_P1_UP:    m[KEYS_PER_PLAYER + JOY_UP]    = 1'b1;
         SC_P1_TRIG1: m[KEYS_PER_PLAYER + JOY_TRIG1] = 1'b1;
         SC_P1_TRIG2: m[KEYS_PER_PLAYER + JOY_TRIG2] = 1'b1;
         SC_P1_START: m[KEYS_PER_PLAYER + JOY_START] = 1'b1;
         SC_P1_COIN:  m[KEYS_PER_PLAYER + JOY_COIN]  = 1'b1;
         SC_F2:       m[KEYS_PER_PLAYER + KEY_FN]    = 1'b1;
         default: ;
      endcase
      return m;
   endfunction

   // One player's key states converted to a joystick-order byte.
   // The function key acts as both start and coin.
   function automatic logic [7:0] key_word(input logic [KEYS_PER_PLAYER-1:0] k);
      logic [7:0] w;
      w            = k[7:0];
      w[JOY_START] = k[JOY_START] | k[KEY_FN];
      w[JOY_COIN]  = k[JOY_COIN]  | k[KEY_FN];
      return w;
   endfunction

   // Reorders a joystick-order byte into control-byte order (active-high).
   function automatic logic [7:0] to_ctrl(input logic [7:0] j);
      logic [7:0] c;
      c[CTRL_COIN]  = j[JOY_COIN];
      c[CTRL_TRIG2] = j[JOY_TRIG2];
      c[CTRL_START] = j[JOY_START];
      c[CTRL_UP]    = j[JOY_UP];
      c[CTRL_DOWN]  = j[JOY_DOWN];
      c[CTRL_TRIG1] = j[JOY_TRIG1];
      c[CTRL_RIGHT] = j[JOY_RIGHT];
      c[CTRL_LEFT]  = j[JOY_LEFT];
      return c;
   endfunction

endpackage

// File: rtl/arcade_coin_stretch.sv
// Module: arcade_coin_stretch
// Stretches a coin press so that the game sees it for at least COIN_FRAMES frames.
// A rising edge on coin_raw loads the counter; this also applies while the counter is running.
// The counter decrements on each frame_tick.
// coin_out is registered and stays high while the counter is non-zero or the raw coin is held.
// Ports:
//  clk_sys    in  system clock
//  RESET      in  synchronous active-high reset; aborts a stretch in progress
//  coin_raw   in  merged raw coin request
//  frame_tick in  one-clock vblank rising-edge pulse
//  coin_out   out stretched coin, active-high
module arcade_coin_stretch
   import arcade_input_pkg::*;
#(
   parameter int COIN_FRAMES = 3
) (
   input  logic clk_sys,
   input  logic RESET,
   input  logic coin_raw,
   input  logic frame_tick,
   output logic coin_out
);

   logic       coin_p0;
   logic [3:0] cnt_p0;
   logic [3:0] cnt_next;
   logic       rise;

   always_comb begin
      rise     = coin_raw & ~coin_p0;
      cnt_next = cnt_p0;
      if (rise)
         cnt_next = 4'(COIN_FRAMES);
      else if (frame_tick && (cnt_p0 != 4'd0))
         cnt_next = cnt_p0 - 4'd1;
   end

   // Stage p0: edge register, frame counter and registered output
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         coin_p0  <= 1'b0;
         cnt_p0   <= 4'd0;
         coin_out <= 1'b0;
      end else begin
         coin_p0  <= coin_raw;
         cnt_p0   <= cnt_next;
         coin_out <= (cnt_next != 4'd0) | coin_raw;
      end
   end

endmodule

// File: rtl/arcade_input_mapper.sv
// Module: arcade_input_mapper
// Player-input front end between hps_io and an arcade core.
// Processing order, per player:
//  1. PS/2 key events are decoded into key states.
//  2. Key states are ORed with the joystick word.
//  3. In upright cabinets, movement and triggers of the other players are shared into player 0.
//  4. Opposing directions are neutralised (SOCD).
//  5. Coin presses are stretched.
//  6. The result is registered as an active-low control byte.
// DIP bytes are loaded from hps_io download index 254.
// RESET does not affect the DIP bytes.
// Optional feature: define ARCADE_INPUT_AUTOFIRE_EN to enable per-player trig1 autofire.
// Ports:
//  clk_sys      in  system clock
//  RESET        in  synchronous active-high reset
//  ps2_key      in  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//  joystick     in  16 bits per player, low byte R,L,D,U,trig1,trig2,start,coin
//  vblank       in  frame timing; rising edge is one frame tick
//  cabinet      in  0 = upright (controls shared into player 0)
//  autofire_on  in  per-player autofire enable
//  ioctl_*      in  hps_io download port
//  ctrl_n       out active-low control byte per player
//  dsw          out DIP bytes
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int         NUM_PLAYERS     = 2,
   parameter int         DSW_BYTES       = 1,
   parameter logic [7:0] DSW_DEFAULT     = 8'hFF,
   parameter int         COIN_FRAMES     = 3,
   parameter int         AUTOFIRE_FRAMES = 4
) (
   input  logic                     clk_sys,
   input  logic                     RESET,
   input  logic [10:0]              ps2_key,
   input  logic [16*NUM_PLAYERS-1:0] joystick,
   input  logic                     vblank,
   input  logic                     cabinet,
   input  logic [NUM_PLAYERS-1:0]   autofire_on,
   input  logic                     ioctl_wr,
   input  logic [7:0]               ioctl_index,
   input  logic [24:0]              ioctl_addr,
   input  logic [7:0]               ioctl_dout,
   output logic [8*NUM_PLAYERS-1:0] ctrl_n,
   output logic [8*DSW_BYTES-1:0]   dsw
);

   logic                key_tog_p0;
   logic [NUM_KEYS-1:0] keys_p0;
   logic [NUM_KEYS-1:0] key_mask;
   logic                vblank_p0;
   logic                frame_tick;

   logic [7:0] kw0;
   logic [7:0] kw1;
   logic [7:0] raw    [NUM_PLAYERS];
   logic [7:0] merged [NUM_PLAYERS];
   logic [5:0] share;

   logic [8*DSW_BYTES-1:0] dsw_q = {DSW_BYTES{DSW_DEFAULT}};

   assign key_mask   = key_decode(ps2_key[8:0]);
   assign frame_tick = vblank & ~vblank_p0;

   // Stage p0: key-event detection, key states and vblank sample.
   // On reset the toggle copy is loaded with the live toggle, so an event
   // arriving together with reset is swallowed rather than replayed.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         key_tog_p0 <= ps2_key[10];
         keys_p0    <= '0;
         vblank_p0  <= 1'b0;
      end else begin
         key_tog_p0 <= ps2_key[10];
         vblank_p0  <= vblank;
         if (ps2_key[10] != key_tog_p0)
            keys_p0 <= (keys_p0 & ~key_mask) | (key_mask & {NUM_KEYS{ps2_key[9]}});
      end
   end

   assign kw0 = key_word(keys_p0[KEYS_PER_PLAYER-1:0]);
   assign kw1 = key_word(keys_p0[NUM_KEYS-1:KEYS_PER_PLAYER]);

   // Merge, cabinet sharing (directions and triggers only) and SOCD
   always_comb begin
      share = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         raw[p] = joystick[16*p +: 8];
         if (p == 0)
            raw[p] = raw[p] | kw0;
         else if (p == 1)
            raw[p] = raw[p] | kw1;
      end
      for (int p = 1; p < NUM_PLAYERS; p++)
         share = share | raw[p][5:0];
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         merged[p] = raw[p];
         if ((p == 0) && !cabinet)
            merged[p][5:0] = merged[p][5:0] | share;
         if (merged[p][JOY_LEFT] && merged[p][JOY_RIGHT]) begin
            merged[p][JOY_LEFT]  = 1'b0;
            merged[p][JOY_RIGHT] = 1'b0;
         end
         if (merged[p][JOY_UP] && merged[p][JOY_DOWN]) begin
            merged[p][JOY_UP]   = 1'b0;
            merged[p][JOY_DOWN] = 1'b0;
         end
      end
   end

   logic [NUM_PLAYERS-1:0] unused_joy_hi;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      logic       coin_s;
      logic       trig1_s;
      logic [7:0] ctrl_p1;

      assign unused_joy_hi[g] = ^joystick[16*g+8 +: 8];

      arcade_coin_stretch #(
         .COIN_FRAMES(COIN_FRAMES)
      ) u_coin (
         .clk_sys    (clk_sys),
         .RESET      (RESET),
         .coin_raw   (merged[g][JOY_COIN]),
         .frame_tick (frame_tick),
         .coin_out   (coin_s)
      );

`ifdef ARCADE_INPUT_AUTOFIRE_EN
      logic [3:0] af_cnt_p0;
      logic       af_phase_p0;
      logic       af_act;

      assign af_act = autofire_on[g] & merged[g][JOY_TRIG1];

      // Stage p0: autofire phase.
      // Phase idles high, so the press clock fires immediately.
      always_ff @(posedge clk_sys) begin
         if (RESET || !af_act) begin
            af_cnt_p0   <= 4'd0;
            af_phase_p0 <= 1'b1;
         end else if (frame_tick) begin
            if (af_cnt_p0 == 4'(AUTOFIRE_FRAMES - 1)) begin
               af_cnt_p0   <= 4'd0;
               af_phase_p0 <= ~af_phase_p0;
            end else begin
               af_cnt_p0 <= af_cnt_p0 + 4'd1;
            end
         end
      end

      assign trig1_s = merged[g][JOY_TRIG1] & (~autofire_on[g] | af_phase_p0);
`else
      assign trig1_s = merged[g][JOY_TRIG1];
`endif

      // Stage p1: registered active-low control byte
      always_ff @(posedge clk_sys) begin
         if (RESET)
            ctrl_p1 <= 8'hFF;
         else
            ctrl_p1 <= ~to_ctrl({coin_s, merged[g][6:5], trig1_s, merged[g][3:0]});
      end

      assign ctrl_n[8*g +: 8] = ctrl_p1;
   end

`ifndef ARCADE_INPUT_AUTOFIRE_EN
   logic unused_autofire;
   assign unused_autofire = ^autofire_on;
`endif

   // DIP bytes: written only from index 254, and only at in-range addresses
   always_ff @(posedge clk_sys) begin
      for (int n = 0; n < DSW_BYTES; n++) begin
         if (ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr == 25'(n)))
            dsw_q[8*n +: 8] <= ioctl_dout;
      end
   end

   assign dsw = dsw_q;

endmodule
